// File: rtl/pipeline_ctrl_if.sv
// Signal bundle between the pipeline datapath and its stall/flush controller.
// The master modport is the controller side; the slave modport is the datapath side.
interface pipeline_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
);
  logic [ADDR_W-1:0] id_rs;
  logic [ADDR_W-1:0] id_rt;
  logic [ADDR_W-1:0] ex_rd;
  logic              ex_mem_read;
  logic              ex_branch_taken;
  logic              ex_long_start;

  logic              pc_write;
  logic              ifid_we;
  logic              idex_we;
  logic              exmem_we;
  logic              memwb_we;
  logic              id_bubble;
  logic              ifid_flush_n;
  logic              idex_flush_n;
  logic              exmem_flush_n;
  logic              memwb_flush_n;
  logic [1:0]        state;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    input  id_rs, id_rt, ex_rd, ex_mem_read, ex_branch_taken, ex_long_start,
    output pc_write, ifid_we, idex_we, exmem_we, memwb_we, id_bubble,
           ifid_flush_n, idex_flush_n, exmem_flush_n, memwb_flush_n,
           state, stall_cycles
  );

  modport slave (
    output id_rs, id_rt, ex_rd, ex_mem_read, ex_branch_taken, ex_long_start,
    input  pc_write, ifid_we, idex_we, exmem_we, memwb_we, id_bubble,
           ifid_flush_n, idex_flush_n, exmem_flush_n, memwb_flush_n,
           state, stall_cycles
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes, multi-cycle EX
// freezes, registered buffer clears and a saturating stall-cycle counter.
//
// state      | meaning
// RUN        | normal flow, hazard inputs evaluated
// LOAD_STALL | single recovery cycle after a load-use bubble
// LONG_BUSY  | EX frozen on a multi-cycle op, WB drains
// BR_FLUSH   | IF/ID and ID/EX cleared, PC holds branch target
module pipeline_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int LONG_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic           clk,
  input  logic           reset,
  pipeline_ctrl_if.master bus
);

  localparam int LC_W = (LONG_CYCLES > 2) ? $clog2(LONG_CYCLES) : 1;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    LONG_BUSY  = 2'd2,
    BR_FLUSH   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [LC_W-1:0]   long_cnt_q, long_cnt_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              ifid_fl_q, idex_fl_q, exmem_fl_q, memwb_fl_q;
  logic              ifid_fl_d, idex_fl_d;

  logic [ADDR_W-1:0] rs, rt, rd;
  logic              loaduse;
  logic              pc_we, ifid_we, idex_we, exmem_we, memwb_we, bubble;

  assign rs = bus.id_rs;
  assign rt = bus.id_rt;
  assign rd = bus.ex_rd;
  assign loaduse = bus.ex_mem_read && (rd != '0) && ((rd == rs) || (rd == rt));

  always_comb begin
    pc_we      = 1'b1;
    ifid_we    = 1'b1;
    idex_we    = 1'b1;
    exmem_we   = 1'b1;
    memwb_we   = 1'b1;
    bubble     = 1'b0;
    state_d    = state_q;
    long_cnt_d = long_cnt_q;
    ifid_fl_d  = 1'b1;
    idex_fl_d  = 1'b1;
    case (state_q)
      RUN: begin
        if (bus.ex_branch_taken) begin
          state_d   = BR_FLUSH;
          ifid_fl_d = 1'b0;
          idex_fl_d = 1'b0;
        end else if (bus.ex_long_start) begin
          pc_we      = 1'b0;
          ifid_we    = 1'b0;
          idex_we    = 1'b0;
          exmem_we   = 1'b0;
          state_d    = LONG_BUSY;
          long_cnt_d = LC_W'(LONG_CYCLES - 2);
        end else if (loaduse) begin
          pc_we   = 1'b0;
          ifid_we = 1'b0;
          bubble  = 1'b1;
          state_d = LOAD_STALL;
        end
      end
      LOAD_STALL: state_d = RUN;
      LONG_BUSY: begin
        pc_we    = 1'b0;
        ifid_we  = 1'b0;
        idex_we  = 1'b0;
        exmem_we = 1'b0;
        if (long_cnt_q == '0) state_d = RUN;
        else                  long_cnt_d = long_cnt_q - LC_W'(1);
      end
      BR_FLUSH: begin
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        idex_we = 1'b0;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    stall_d = (!pc_we && (stall_q != '1)) ? stall_q + CNT_W'(1) : stall_q;
  end

  // Flush outputs come straight from flops so the async clears never see a glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RUN;
      long_cnt_q <= '0;
      stall_q    <= '0;
      ifid_fl_q  <= 1'b0;
      idex_fl_q  <= 1'b0;
      exmem_fl_q <= 1'b0;
      memwb_fl_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      long_cnt_q <= long_cnt_d;
      stall_q    <= stall_d;
      ifid_fl_q  <= ifid_fl_d;
      idex_fl_q  <= idex_fl_d;
      exmem_fl_q <= 1'b1;
      memwb_fl_q <= 1'b1;
    end
  end

  assign bus.pc_write      = pc_we;
  assign bus.ifid_we       = ifid_we;
  assign bus.idex_we       = idex_we;
  assign bus.exmem_we      = exmem_we;
  assign bus.memwb_we      = memwb_we;
  assign bus.id_bubble     = bubble;
  assign bus.ifid_flush_n  = ifid_fl_q;
  assign bus.idex_flush_n  = idex_fl_q;
  assign bus.exmem_flush_n = exmem_fl_q;
  assign bus.memwb_flush_n = memwb_fl_q;
  assign bus.state         = state_q;
  assign bus.stall_cycles  = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: a schedule-queue model checked every negedge, plus
// hand-computed literal expectations along a directed stimulus sequence.
module tb_pipeline_ctrl;
  localparam int AW   = 4;
  localparam int LC   = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  // Cycle kinds a scheduled (non-free) cycle can take, coded as the state it shows.
  localparam int K_HOLD = 1;
  localparam int K_LONG = 2;
  localparam int K_BRF  = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;

  pipeline_ctrl_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

  pipeline_ctrl #(.ADDR_W(AW), .LONG_CYCLES(LC), .CNT_W(CW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: a queue of cycles already committed by an earlier event.
  int sched[$];
  int exp_cnt = 0;
  bit flush_ok = 1'b0;
  int m_k, e_st;
  bit e_pc, e_ifw, e_idw, e_exw, e_wbw, e_bub, e_fl;

  always @(posedge clk or posedge reset) flush_ok = !reset;

  always @(negedge clk) begin
    if (reset) begin
      sched.delete();
      exp_cnt = 0;
      chk("m_rst_state", bus.state, 0);
      chk("m_rst_cnt", bus.stall_cycles, 0);
      chk("m_rst_flush", {bus.ifid_flush_n, bus.idex_flush_n, bus.exmem_flush_n, bus.memwb_flush_n}, 0);
    end else begin
      {e_pc, e_ifw, e_idw, e_exw, e_wbw} = 5'b11111;
      e_bub = 1'b0;
      e_fl  = 1'b1;
      e_st  = 0;
      if (sched.size() > 0) begin
        m_k  = sched.pop_front();
        e_st = m_k;
        if (m_k == K_LONG) {e_pc, e_ifw, e_idw, e_exw} = 4'b0000;
        else if (m_k == K_BRF) begin
          {e_pc, e_ifw, e_idw} = 3'b000;
          e_fl = 1'b0;
        end
      end else if (bus.ex_branch_taken) begin
        sched.push_back(K_BRF);
      end else if (bus.ex_long_start) begin
        {e_pc, e_ifw, e_idw, e_exw} = 4'b0000;
        repeat (LC - 1) sched.push_back(K_LONG);
      end else if (bus.ex_mem_read && bus.ex_rd != 0 &&
                   (bus.ex_rd == bus.id_rs || bus.ex_rd == bus.id_rt)) begin
        e_pc  = 1'b0;
        e_ifw = 1'b0;
        e_bub = 1'b1;
        sched.push_back(K_HOLD);
      end
      chk("m_state", bus.state, e_st);
      chk("m_pc_write", bus.pc_write, e_pc);
      chk("m_ifid_we", bus.ifid_we, e_ifw);
      chk("m_idex_we", bus.idex_we, e_idw);
      chk("m_exmem_we", bus.exmem_we, e_exw);
      chk("m_memwb_we", bus.memwb_we, e_wbw);
      chk("m_bubble", bus.id_bubble, e_bub);
      chk("m_ifid_flush_n", bus.ifid_flush_n, flush_ok & e_fl);
      chk("m_idex_flush_n", bus.idex_flush_n, flush_ok & e_fl);
      chk("m_exmem_flush_n", bus.exmem_flush_n, flush_ok);
      chk("m_memwb_flush_n", bus.memwb_flush_n, flush_ok);
      chk("m_stall_cycles", bus.stall_cycles, exp_cnt);
      if (!e_pc && exp_cnt < CMAX) exp_cnt++;
    end
  end

  task automatic drive(input bit br, input bit lg, input bit mr,
                       input int rd, input int rs, input int rt);
    bus.ex_branch_taken = br;
    bus.ex_long_start   = lg;
    bus.ex_mem_read     = mr;
    bus.ex_rd           = AW'(rd);
    bus.id_rs           = AW'(rs);
    bus.id_rt           = AW'(rt);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    tick();
    tick();
    #1;
    chk("lit_rst_flush", {bus.ifid_flush_n, bus.idex_flush_n, bus.exmem_flush_n, bus.memwb_flush_n}, 0);
    chk("lit_rst_state", bus.state, 0);
    chk("lit_rst_cnt", bus.stall_cycles, 0);
    reset = 1'b0;
    #1;
    chk("lit_flush_before_edge", bus.ifid_flush_n, 0);
    tick();
    chk("lit_flush_after_edge", {bus.ifid_flush_n, bus.idex_flush_n, bus.exmem_flush_n, bus.memwb_flush_n}, 4'b1111);
    tick();

    // load-use on rt, held for two cycles: the second cycle must not re-stall
    drive(0, 0, 1, 5, 0, 5);
    #1;
    chk("lit_lu_pc", bus.pc_write, 0);
    chk("lit_lu_ifid_we", bus.ifid_we, 0);
    chk("lit_lu_idex_we", bus.idex_we, 1);
    chk("lit_lu_bubble", bus.id_bubble, 1);
    tick();
    #1;
    chk("lit_lu_state1", bus.state, 1);
    chk("lit_lu_hold_pc", bus.pc_write, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("lit_lu_back_run", bus.state, 0);
    chk("lit_lu_cnt", bus.stall_cycles, 1);

    drive(0, 0, 1, 0, 0, 0);
    #1;
    chk("lit_rd0_pc", bus.pc_write, 1);
    tick();
    drive(0, 0, 1, 7, 7, 3);
    #1;
    chk("lit_rs_match_pc", bus.pc_write, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 5, 0, 5);
    #1;
    chk("lit_noload_pc", bus.pc_write, 1);
    tick();

    // taken branch
    drive(1, 0, 0, 0, 0, 0);
    #1;
    chk("lit_br_pc", bus.pc_write, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("lit_br_state", bus.state, 3);
    chk("lit_br_flush", {bus.ifid_flush_n, bus.idex_flush_n, bus.exmem_flush_n, bus.memwb_flush_n}, 4'b0011);
    chk("lit_br_pc_hold", bus.pc_write, 0);
    tick();
    #1;
    chk("lit_br_run", bus.state, 0);
    chk("lit_br_cnt", bus.stall_cycles, 3);

    // multi-cycle op, with events presented while busy that must be ignored
    drive(0, 1, 0, 0, 0, 0);
    #1;
    chk("lit_long_start", {bus.pc_write, bus.ifid_we, bus.idex_we, bus.exmem_we, bus.memwb_we}, 5'b00001);
    tick();
    drive(1, 0, 1, 5, 5, 5);
    for (int i = 0; i < LC - 1; i++) begin
      #1;
      chk("lit_long_busy", {bus.state, bus.pc_write, bus.memwb_we}, 4'b1001);
      if (i == LC - 2) drive(0, 0, 0, 0, 0, 0);
      tick();
    end
    #1;
    chk("lit_long_done_pc", bus.pc_write, 1);
    chk("lit_long_cnt", bus.stall_cycles, 7);

    // simultaneous events: branch wins
    drive(1, 1, 1, 5, 5, 5);
    #1;
    chk("lit_simul_pc", bus.pc_write, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("lit_simul_state", bus.state, 3);
    tick();
    #1;
    chk("lit_simul_run", bus.state, 0);
    chk("lit_simul_cnt", bus.stall_cycles, 8);

    // 20 more stall cycles: counter must stop at all-ones
    for (int n = 0; n < 5; n++) begin
      drive(0, 1, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 0);
      repeat (LC - 1) tick();
    end
    #1;
    chk("lit_sat_cnt", bus.stall_cycles, CMAX);

    // reset in the middle of a long op
    drive(0, 1, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("lit_abort_state", bus.state, 0);
    chk("lit_abort_cnt", bus.stall_cycles, 0);
    chk("lit_abort_flush", {bus.ifid_flush_n, bus.idex_flush_n, bus.exmem_flush_n, bus.memwb_flush_n}, 0);
    tick();
    reset = 1'b0;
    tick();
    #1;
    chk("lit_abort_we", {bus.pc_write, bus.ifid_we, bus.idex_we, bus.exmem_we, bus.memwb_we}, 5'b11111);
    chk("lit_abort_state_run", bus.state, 0);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
